// File: rtl/frm_prs_if.sv
// ============================================================================
// Module   : frm_prs_if
// Purpose  : Byte-in / payload-and-verdict-out bundle for the frame parser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frm_prs_if;
  logic [7:0]  iv_data;
  logic        i_data_wr;
  logic [7:0]  ov_pl_data;
  logic        o_pl_valid;
  logic        o_pl_sop;
  logic        o_pl_eop;
  logic        o_frm_ok;
  logic        o_frm_err;
  logic [15:0] ov_frm_cnt;
  logic [15:0] ov_err_cnt;

  modport slave (
    input  iv_data, i_data_wr,
    output ov_pl_data, o_pl_valid, o_pl_sop, o_pl_eop,
    output o_frm_ok, o_frm_err, ov_frm_cnt, ov_err_cnt
  );

  modport master (
    output iv_data, i_data_wr,
    input  ov_pl_data, o_pl_valid, o_pl_sop, o_pl_eop,
    input  o_frm_ok, o_frm_err, ov_frm_cnt, ov_err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/frm_prs.sv
// ============================================================================
// Module   : frm_prs
// Purpose  : Sync-hunting, length-delimited frame parser with XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frm_prs #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 64,
  parameter int         TIMEOUT   = 16
) (
  input  wire logic  i_clk,
  input  wire logic  i_rst_n,
  frm_prs_if.slave   bus
);

  localparam int             TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]     MAX_L   = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_xor, w_xor_nxt;
  logic [7:0]      r_rem, w_rem_nxt;
  logic            r_first, w_first_nxt;
  logic [TW-1:0]   r_to, w_to_nxt;
  logic [7:0]      r_pl_data, w_pl_data;
  logic            r_pl_valid, w_pl_valid;
  logic            r_sop, w_sop;
  logic            r_eop, w_eop;
  logic            r_ok, w_ok;
  logic            r_err, w_err;
  logic [15:0]     r_frm_cnt, r_err_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_xor_nxt   = r_xor;
    w_rem_nxt   = r_rem;
    w_first_nxt = r_first;
    w_to_nxt    = r_to;
    w_pl_data   = 8'h00;
    w_pl_valid  = 1'b0;
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;

    if (bus.i_data_wr) begin
      // A byte always beats an expiring timeout.
      w_to_nxt = '0;
      case (r_state)
        ST_HUNT: begin
          if (bus.iv_data == SYNC_BYTE) w_state_nxt = ST_LEN;
        end
        ST_LEN: begin
          if (bus.iv_data == 8'd0 || bus.iv_data > MAX_L) begin
            w_err       = 1'b1;
            w_state_nxt = ST_HUNT;
          end else begin
            w_rem_nxt   = bus.iv_data;
            w_xor_nxt   = bus.iv_data;
            w_first_nxt = 1'b1;
            w_state_nxt = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          w_pl_data   = bus.iv_data;
          w_pl_valid  = 1'b1;
          w_sop       = r_first;
          w_eop       = (r_rem == 8'd1);
          w_first_nxt = 1'b0;
          w_xor_nxt   = r_xor ^ bus.iv_data;
          w_rem_nxt   = r_rem - 8'd1;
          if (r_rem == 8'd1) w_state_nxt = ST_CHK;
        end
        ST_CHK: begin
          w_ok        = (bus.iv_data == r_xor);
          w_err       = (bus.iv_data != r_xor);
          w_state_nxt = ST_HUNT;
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end else if (r_state != ST_HUNT) begin
      if (r_to == TO_LAST) begin
        w_err       = 1'b1;
        w_to_nxt    = '0;
        w_state_nxt = ST_HUNT;
      end else begin
        w_to_nxt = r_to + 1'b1;
      end
    end else begin
      w_to_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_HUNT;
      r_xor      <= 8'h00;
      r_rem      <= 8'h00;
      r_first    <= 1'b0;
      r_to       <= '0;
      r_pl_data  <= 8'h00;
      r_pl_valid <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_frm_cnt  <= 16'h0000;
      r_err_cnt  <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_xor      <= w_xor_nxt;
      r_rem      <= w_rem_nxt;
      r_first    <= w_first_nxt;
      r_to       <= w_to_nxt;
      r_pl_data  <= w_pl_data;
      r_pl_valid <= w_pl_valid;
      r_sop      <= w_sop;
      r_eop      <= w_eop;
      r_ok       <= w_ok;
      r_err      <= w_err;
      if (w_ok && r_frm_cnt != 16'hFFFF) r_frm_cnt <= r_frm_cnt + 16'd1;
      if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign bus.ov_pl_data = r_pl_data;
  assign bus.o_pl_valid = r_pl_valid;
  assign bus.o_pl_sop   = r_sop;
  assign bus.o_pl_eop   = r_eop;
  assign bus.o_frm_ok   = r_ok;
  assign bus.o_frm_err  = r_err;
  assign bus.ov_frm_cnt = r_frm_cnt;
  assign bus.ov_err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_frm_prs.sv
// ============================================================================
// Module   : tb_frm_prs
// Purpose  : Scoreboard bench for frm_prs with a frame-level reference parser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frm_prs;
  localparam int MAX_LEN = 64;
  localparam int TIMEOUT = 16;

  typedef struct {
    int         kind;   // 0 payload, 1 good verdict, 2 error verdict
    logic [7:0] data;
    logic       sop;
    logic       eop;
    int         ed;     // clock edge that registers the output
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   edge_cnt = 0;
  int   vectors  = 0;
  int   fails    = 0;
  int   exp_ok   = 0;
  int   exp_err  = 0;
  int   mon_ok   = 0;
  int   mon_err  = 0;
  ev_t  exp_q[$];
  int   sched[$];   // -1 = idle slot, otherwise a byte

  frm_prs_if bus ();

  frm_prs #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] d, input logic s, input logic e, input int ed);
    ev_t v;
    v.kind = kind; v.data = d; v.sop = s; v.eop = e; v.ed = ed;
    exp_q.push_back(v);
  endtask

  // Frame-level reference: walks the arrival list (edge, byte) and applies
  // the framing rules directly. With cut set, the stream ends in a reset,
  // so a frame left unfinished produces no verdict.
  task automatic model(input int start, input bit cut);
    int         te[$];
    logic [7:0] bv[$];
    int         n, i, j, last, len;
    logic [7:0] x;
    bit         aborted;
    foreach (sched[k]) if (sched[k] >= 0) begin
      te.push_back(start + k);
      bv.push_back(8'(sched[k]));
    end
    n = te.size();
    i = 0;
    while (i < n) begin
      if (bv[i] != 8'hA5) begin i++; continue; end
      last = te[i];
      j = i + 1;
      if (j >= n || te[j] - last > TIMEOUT) begin
        if (!(j >= n && cut)) begin push_ev(2, 0, 0, 0, last + TIMEOUT); exp_err++; end
        i = j;
        continue;
      end
      len  = int'(bv[j]);
      last = te[j];
      if (len == 0 || len > MAX_LEN) begin
        push_ev(2, 0, 0, 0, te[j]); exp_err++;
        i = j + 1;
        continue;
      end
      x = bv[j];
      aborted = 0;
      for (int k = 1; k <= len; k++) begin
        j++;
        if (j >= n || te[j] - last > TIMEOUT) begin aborted = 1; break; end
        push_ev(0, bv[j], k == 1, k == len, te[j]);
        x    = x ^ bv[j];
        last = te[j];
      end
      if (!aborted) begin
        j++;
        aborted = (j >= n || te[j] - last > TIMEOUT);
      end
      if (aborted) begin
        if (!(j >= n && cut)) begin push_ev(2, 0, 0, 0, last + TIMEOUT); exp_err++; end
        i = j;
        continue;
      end
      if (bv[j] == x) begin push_ev(1, 0, 0, 0, te[j]); exp_ok++; end
      else            begin push_ev(2, 0, 0, 0, te[j]); exp_err++; end
      i = j + 1;
    end
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) sched.push_back(-1);
  endtask

  task automatic add_b(input logic [7:0] b, input int gap);
    add_idle(gap);
    sched.push_back(int'(b));
  endtask

  // Bytes are taken most-significant first from a packed string.
  task automatic add_str(input logic [127:0] s, input int n, input int gap);
    for (int k = 0; k < n; k++) add_b(s[8*(n-1-k) +: 8], gap);
  endtask

  function automatic int rgap();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
    if (r < 4)  return int'($urandom_range(1, 3));
    return 0;
  endfunction

  task automatic gen_random(input int nfr);
    for (int f = 0; f < nfr; f++) begin
      int         ng, r, len;
      logic [7:0] x, b;
      ng = int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) add_b(8'($urandom_range(0, 255)), rgap());
      add_b(8'hA5, rgap());
      r = int'($urandom_range(0, 19));
      if (r == 0)      len = 0;
      else if (r == 1) len = int'($urandom_range(MAX_LEN + 1, 255));
      else if (r < 4)  len = int'($urandom_range(1, MAX_LEN));
      else             len = int'($urandom_range(1, 12));
      add_b(8'(len), rgap());
      if (len == 0 || len > MAX_LEN) continue;
      x = 8'(len);
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom_range(0, 255));
        x = x ^ b;
        add_b(b, rgap());
      end
      if ($urandom_range(0, 5) == 0) x = x ^ 8'($urandom_range(1, 255));
      add_b(x, rgap());
    end
  endtask

  task automatic play(input bit cut);
    int start;
    @(negedge clk);
    start = edge_cnt + 1;
    model(start, cut);
    foreach (sched[k]) begin
      if (sched[k] < 0) begin
        bus.i_data_wr = 1'b0;
        bus.iv_data   = 8'($urandom_range(0, 255));
      end else begin
        bus.i_data_wr = 1'b1;
        bus.iv_data   = 8'(sched[k]);
      end
      @(negedge clk);
    end
    bus.i_data_wr = 1'b0;
    sched.delete();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frm_cnt"}, 32'(bus.ov_frm_cnt), 32'(exp_ok));
    check({tag, "_err_cnt"}, 32'(bus.ov_err_cnt), 32'(exp_err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pl_data"},  32'(bus.ov_pl_data), 32'h0);
    check({tag, "_pl_valid"}, 32'(bus.o_pl_valid), 32'h0);
    check({tag, "_pl_sop"},   32'(bus.o_pl_sop),   32'h0);
    check({tag, "_pl_eop"},   32'(bus.o_pl_eop),   32'h0);
    check({tag, "_frm_ok"},   32'(bus.o_frm_ok),   32'h0);
    check({tag, "_frm_err"},  32'(bus.o_frm_err),  32'h0);
    check({tag, "_frm_cnt"},  32'(bus.ov_frm_cnt), 32'h0);
    check({tag, "_err_cnt"},  32'(bus.ov_err_cnt), 32'h0);
  endtask

  // Monitor: pops one expected event per observed output event.
  initial begin
    ev_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (exp_q.size() > 0 && exp_q[0].ed < edge_cnt) begin
          e = exp_q.pop_front();
          vectors++;
          fails++;
          $display("FAIL missing_event: got none expected kind %0d data %0h at edge %0d", e.kind, e.data, e.ed);
        end
        if (bus.o_pl_valid || bus.o_frm_ok || bus.o_frm_err) begin
          kind = bus.o_frm_err ? 2 : (bus.o_frm_ok ? 1 : 0);
          if (bus.o_frm_ok && bus.o_frm_err) check("ok_err_exclusive", 32'd1, 32'd0);
          if (exp_q.size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d data %0h at edge %0d expected none", kind, bus.ov_pl_data, edge_cnt);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_edge", 32'(edge_cnt), 32'(e.ed));
            if (kind == 0)
              check("payload_data_sop_eop", {22'd0, bus.ov_pl_data, bus.o_pl_sop, bus.o_pl_eop},
                    {22'd0, e.data, e.sop, e.eop});
          end
          if (bus.o_frm_ok) begin
            mon_ok++;
            check("frm_cnt_with_pulse", 32'(bus.ov_frm_cnt), 32'(mon_ok));
          end
          if (bus.o_frm_err) begin
            mon_err++;
            check("err_cnt_with_pulse", 32'(bus.ov_err_cnt), 32'(mon_err));
          end
        end
      end
    end
  end

  initial begin
    bus.iv_data   = 8'h00;
    bus.i_data_wr = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    add_str(48'hA5_03_11_22_33_03, 6, 0); add_idle(TIMEOUT + 3);
    play(0); check_counts("good");

    add_str(40'hA5_02_0F_F0_00, 5, 0); add_idle(TIMEOUT + 3);
    play(0); check_counts("badchk");

    add_str(32'hA5_00_A5_41, 4, 0); add_str(40'hA5_02_AA_BB_13, 5, 0); add_idle(TIMEOUT + 3);
    play(0); check_counts("badlen");

    add_str(24'hA5_04_01, 3, 0); add_idle(TIMEOUT + 3);
    play(0); check_counts("timeout");

    add_str(24'hA5_04_01, 3, 0); add_idle(TIMEOUT - 1); add_str(32'h02_03_04_00, 4, 0);
    add_idle(TIMEOUT + 3);
    play(0); check_counts("byte_wins");

    add_str(24'h00_FF_A4, 3, 0); add_str(32'hA5_01_7E_7F, 4, 3); add_idle(TIMEOUT + 3);
    play(0); check_counts("hunt_gaps");

    gen_random(60); add_idle(TIMEOUT + 3);
    play(0); check_counts("random");

    // Reset lands after two of five payload bytes.
    add_str(32'hA5_05_01_02, 4, 0); add_idle(1);
    play(1);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    check_zero("midreset_hold");
    mon_ok = 0; mon_err = 0; exp_ok = 0; exp_err = 0;
    rst_n = 1'b1;

    add_str(40'hA5_02_AA_BB_13, 5, 0); add_idle(TIMEOUT + 3);
    play(0); check_counts("after_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
